// File: rtl/alu_result_tx_ctrl_pkg.sv
// alu_result_tx_ctrl_pkg: shared widths and FSM encoding for the ALU result TX path
package alu_result_tx_ctrl_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int WORD_W_DEF = 16;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_B0 = 2'd1,
      SEND_B1 = 2'd2
   } state_t;
endpackage

// File: rtl/alu_result_tx_ctrl_word_hold_slot.sv
// word_hold_slot: one word register with a valid flag; load wins over clear
module word_hold_slot #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         LOAD,
   input  logic         CLR,
   input  logic [W-1:0] D,
   output logic [W-1:0] Q,
   output logic         VALID
);
   // hold the word until reloaded; clearing only drops the valid flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         Q     <= '0;
         VALID <= 1'b0;
      end else if (LOAD) begin
         Q     <= D;
         VALID <= 1'b1;
      end else if (CLR) begin
         VALID <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_result_tx_ctrl.sv
// alu_result_tx_ctrl: capture ALU results and send each as two bytes over valid/ready
module alu_result_tx_ctrl
   import alu_result_tx_ctrl_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int WORD_W    = WORD_W_DEF,
   parameter int LSB_FIRST = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] ALU_OUT,
   input  logic              OUT_VALID,
   output logic [DATA_W-1:0] TX_DATA,
   output logic              TX_VALID,
   input  logic              TX_READY,
   output logic              BUSY,
   output logic              DROP
);
   localparam bit LSB = LSB_FIRST != 0;
   state_t state, state_nxt;
   logic hs, done, act_load, act_clr, pend_load, pend_clr, drop_nxt, busy_nxt;
   logic act_v, pend_v;
   logic [WORD_W-1:0] act_d, act_q, pend_q;
   logic [DATA_W-1:0] lo_byte, hi_byte;

   word_hold_slot #(.W(WORD_W)) u_act (
      .CLK(CLK), .RST(RST), .LOAD(act_load), .CLR(act_clr),
      .D(act_d), .Q(act_q), .VALID(act_v)
   );

   word_hold_slot #(.W(WORD_W)) u_pend (
      .CLK(CLK), .RST(RST), .LOAD(pend_load), .CLR(pend_clr),
      .D(ALU_OUT), .Q(pend_q), .VALID(pend_v)
   );

   assign hs      = TX_VALID && TX_READY;
   assign lo_byte = act_q[DATA_W-1:0];
   assign hi_byte = act_q[WORD_W-1:DATA_W];

   // state, busy and drop all update together on the clock edge
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         BUSY  <= 1'b0;
         DROP  <= 1'b0;
      end else begin
         state <= state_nxt;
         BUSY  <= busy_nxt;
         DROP  <= drop_nxt;
      end
   end

   // slot control and next state; on word completion the pending word (else a new result) refills ACT
   always_comb begin
      done      = state == SEND_B1 && hs;
      act_load  = (state == IDLE && OUT_VALID) || (done && (pend_v || OUT_VALID));
      act_d     = (done && pend_v) ? pend_q : ALU_OUT;
      act_clr   = done && !pend_v && !OUT_VALID;
      pend_clr  = done && pend_v;
      pend_load = OUT_VALID && state != IDLE && (done ? pend_v : !pend_v);
      drop_nxt  = OUT_VALID && state != IDLE && pend_v && !done;
      state_nxt = state == IDLE    ? (OUT_VALID ? SEND_B0 : IDLE) :
                  state == SEND_B0 ? (hs ? SEND_B1 : SEND_B0) :
                  state == SEND_B1 ? (done ? (act_load ? SEND_B0 : IDLE) : SEND_B1) : IDLE;
      busy_nxt  = state_nxt != IDLE || pend_load || (pend_v && !pend_clr);
   end

   // byte mux: first byte in SEND_B0, the other in SEND_B1, zero when idle
   always_comb begin
      TX_VALID = state != IDLE && act_v;
      TX_DATA  = !TX_VALID ? '0 : ((state == SEND_B0) == LSB) ? lo_byte : hi_byte;
   end
endmodule

// File: doc/alu_result_tx_ctrl.md
Name: alu_result_tx_ctrl

Overview:
- Downstream stage of the ALU arithmetic unit: captures each 16-bit ALU result and serialises it as two bytes to the UART TX path over a valid/ready handshake.
- Provides one pending slot so back-to-back ALU results are absorbed while a word is being sent.
- Signals dropped results and reports busy status to the system controller.
- Sits in the reference clock domain, between the ALU and the TX-side data synchroniser.

Parameters:
- DATA_W, 8, byte width on the TX side.
- WORD_W, 16, ALU result width. Must equal 2*DATA_W.
- LSB_FIRST, 1, 1 = low byte sent first, 0 = high byte sent first.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ALU_OUT  in  WORD_W  ALU result.
- OUT_VALID  in  1  one-cycle pulse: ALU_OUT valid this cycle.
- TX_DATA  out  DATA_W  byte presented to TX.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  TX accepts the byte when TX_VALID && TX_READY at a rising edge.
- BUSY  out  1  high when the active or the pending slot is occupied.
- DROP  out  1  one-cycle pulse: an incoming result was discarded.

Behaviour:
- Reset (RST=1 at an edge): state=IDLE; TX_DATA=0, TX_VALID=0, BUSY=0, DROP=0; both slots empty. Reset applies mid-word: the partial word and the pending word are discarded, and no further bytes are sent.
- Storage:
  - ACT register (WORD_W) with a valid flag.
  - PEND register (WORD_W) with a valid flag.
- FSM states: IDLE, SEND_B0, SEND_B1.
- IDLE:
  - OUT_VALID=1 -> ALU_OUT is loaded into ACT; go to SEND_B0 next cycle.
  - Latency: OUT_VALID at edge N -> TX_VALID=1 after edge N+1.
- SEND_B0:
  - TX_VALID=1; TX_DATA = ACT[7:0] if LSB_FIRST=1, else ACT[15:8].
  - Handshake -> go to SEND_B1.
- SEND_B1:
  - TX_VALID=1; TX_DATA = the other byte.
  - Handshake -> word complete.
  - If PEND is valid: move PEND into ACT, clear PEND, go to SEND_B0 with no idle cycle. Otherwise go to IDLE with TX_VALID=0.
- Handshake rules:
  - TX_DATA is stable while TX_VALID=1 and TX_READY=0.
  - TX_VALID never deasserts before acceptance.
  - TX_READY is ignored while TX_VALID=0.
- OUT_VALID while not IDLE:
  - PEND empty -> ALU_OUT is captured into PEND.
  - PEND full, and this is not the word-complete cycle -> the result is discarded, DROP=1 for one cycle, and PEND is unchanged.
- Simultaneous events:
  - Word-complete edge with PEND full and OUT_VALID=1: PEND moves to ACT and the new ALU_OUT enters PEND. No drop.
  - Word-complete edge with PEND empty and OUT_VALID=1: the new ALU_OUT goes directly into ACT; go to SEND_B0. No drop and no idle cycle.
- BUSY = (state != IDLE) || PEND valid. It is registered and updates on the same edge as the state.
- DROP is registered and low in every cycle except the discard cycle.
- No arithmetic: byte selection is pure slicing, and the ALU_OUT value is not interpreted (a zero result is still sent).

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, SEND_B0=2'd1, SEND_B1=2'd2).
  - DATA_W/WORD_W defaults, shared with the UART TX and the ALU.
- Natural sub-module: word_hold_slot. It is one WORD_W register with a valid flag and load/clear controls, instantiated twice (ACT, PEND).
- The FSM and byte mux stay in the top module.

Test Plan:
- Single result: ALU_OUT=16'hA55A pulse, TX_READY=1 -> bytes 8'h5A then 8'h A5 on consecutive cycles; BUSY returns to 0 after the second accept; DROP stays 0.
- Backpressure: ALU_OUT=16'h1234, TX_READY=0 for 5 cycles -> TX_DATA held at 8'h34 with TX_VALID=1 throughout; bytes 34 then 12 after READY rises.
- Pending and drop: TX_READY=0; pulses 16'h0001, 16'h0002, 16'h0003 -> 0001 active, 0002 pending, 0003 dropped with a single DROP pulse; after release the bytes are 01,00,02,00 with no gap between words.
- Simultaneous: OUT_VALID=16'hBEEF on the same edge that the high byte of the previous word is accepted (PEND full with 16'hCAFE) -> CAFE sent next, then BEEF; DROP=0.
- Reset mid-word: RST=1 after byte 0 is accepted -> TX_VALID=0, BUSY=0 the next cycle; the high byte is never sent; a new result sends normally.
- LSB_FIRST=0: 16'hA55A -> bytes A5 then 5A.
